// File: rtl/seq_sub_32_pkg.sv
// Shared types and constants for the sequential slice subtractor.
// Optional add mode is enabled by defining SEQ_SUB_ADD_MODE_EN.
package seq_sub_32_pkg;
    localparam int SLICE      = 8;
    localparam int WIDTH_DEF  = 32;
    localparam int NSLICE_DEF = WIDTH_DEF / SLICE;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(NSLICE_DEF);
endpackage

// File: rtl/seq_sub_32_if.sv
// Handshake/operand/result bundle for seq_sub_32.
// The op select only exists when SEQ_SUB_ADD_MODE_EN is defined.
interface seq_sub_32_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
`ifdef SEQ_SUB_ADD_MODE_EN
    logic             op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

`ifdef SEQ_SUB_ADD_MODE_EN
    modport master (output start, in1, in2, op, input busy, done, diff, bout, ovf, zero);
    modport slave  (input start, in1, in2, op, output busy, done, diff, bout, ovf, zero);
`else
    modport master (output start, in1, in2, input busy, done, diff, bout, ovf, zero);
    modport slave  (input start, in1, in2, output busy, done, diff, bout, ovf, zero);
`endif
endinterface

// File: rtl/seq_sub_32_cla_8.sv
// 8-bit carry-lookahead adder slice built from prefix group generate/propagate terms.
// ovf is the carry into bit 7 XOR the carry out of bit 7.
module cla_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ovf,
    output logic       pout,
    output logic       gout
);
    logic [7:0] p, g, grp_p, grp_g;
    logic [8:0] c;

    always_comb begin
        p     = a ^ b;
        g     = a & b;
        grp_g = '0;
        grp_p = '0;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                grp_g[i] = g[i];
                grp_p[i] = p[i];
            end else begin
                grp_g[i] = g[i] | (p[i] & grp_g[i-1]);
                grp_p[i] = p[i] & grp_p[i-1];
            end
            c[i+1] = grp_g[i] | (grp_p[i] & cin);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];
    assign ovf  = c[8] ^ c[7];
    assign pout = grp_p[7];
    assign gout = grp_g[7];
endmodule

// File: rtl/seq_sub_32.sv
// Multi-cycle subtractor: one 8-bit slice per cycle through a shared cla_8, LSB slice first.
// Defining SEQ_SUB_ADD_MODE_EN adds an op input that selects add instead of subtract.
module seq_sub_32
    import seq_sub_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    seq_sub_32_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_w(NSLICE);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, diff_q, diff_d;
    logic             carry_q, carry_d;
    logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
`ifdef SEQ_SUB_ADD_MODE_EN
    logic             add_q, add_d;
`endif

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout, slice_ovf;
    logic             slice_pout_unused, slice_gout_unused;

    // Operands shift right each RUN cycle so the adder always sees the low slice.
    cla_8 u_cla (
        .a    (opa_q[SLICE-1:0]),
        .b    (opb_q[SLICE-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .ovf  (slice_ovf),
        .pout (slice_pout_unused),
        .gout (slice_gout_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`ifdef SEQ_SUB_ADD_MODE_EN
        add_d   = add_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.in1;
`ifdef SEQ_SUB_ADD_MODE_EN
                    add_d   = bus.op;
                    opb_d   = bus.op ? bus.in2 : ~bus.in2;
                    carry_d = ~bus.op;
`else
                    opb_d   = ~bus.in2;
                    carry_d = 1'b1;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[int'(cnt_q)*SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                opa_d   = opa_q >> SLICE;
                opb_d   = opb_q >> SLICE;
                if (cnt_q == CW'(NSLICE - 1)) begin
                    ovf_d   = slice_ovf;
`ifdef SEQ_SUB_ADD_MODE_EN
                    bout_d  = add_q ? slice_cout : ~slice_cout;
`else
                    bout_d  = ~slice_cout;
`endif
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SEQ_SUB_ADD_MODE_EN
            add_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`ifdef SEQ_SUB_ADD_MODE_EN
            add_q   <= add_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: doc/seq_sub_32.md
Name: seq_sub_32

Overview:
Multi-cycle two's-complement subtractor (diff = in1 - in2) for the simple ALU.
- Processes the operand one SLICE-bit slice per cycle, LSB slice first, through a single 8-bit carry-lookahead adder slice.
- The inter-slice carry is held in a register between cycles.
- Start/busy/done handshake; serves ALU subtract/compare ops where area matters more than latency.

Parameters:
WIDTH, 32, operand and result width; must be an integer multiple of SLICE
SLICE, 8, bits processed per cycle; fixed at 8 to match the adder slice
NSLICE, WIDTH/SLICE (=4), derived slice count; not user-overridable

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only in IDLE
in1  input  WIDTH  minuend; sampled on accept cycle only
in2  input  WIDTH  subtrahend; sampled on accept cycle only
busy  output  1  high from cycle after accept through last RUN cycle
done  output  1  one-cycle pulse; results valid
diff  output  WIDTH  in1 - in2 modulo 2^WIDTH
bout  output  1  unsigned borrow = NOT final carry-out (1 when in1 < in2 unsigned)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  diff == 0

Behaviour:
- Reset (async, reset_n low): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0, zero=0; slice counter=0; carry reg=0. Reset asserted mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE & start=1 (accept):
  - latch in1, and ~in2 (bitwise invert) into operand shift registers;
  - carry reg <= 1 (the +1 of two's complement); cnt <= 0; -> RUN.
- RUN, each cycle:
  - slice adds in1 slice[cnt] + ~in2 slice[cnt] + carry reg;
  - sum is written to diff bits [cnt*SLICE +: SLICE]; carry reg <= slice carry-out; cnt++.
  - On cnt==NSLICE-1: capture ovf from that slice's MSB carry XOR, bout <= ~carry-out; -> DONE.
- DONE: done=1, zero=(diff==0), busy=0; -> IDLE next cycle.
- Latency: accept at cycle t -> RUN cycles t+1..t+NSLICE -> done high at cycle t+NSLICE+1 (t+5 for defaults).
- diff/bout/ovf/zero hold their values after DONE until the next accept. diff is undefined-but-stable while busy; do not sample it before done.
- start while busy or in DONE is ignored and not queued. Operand changes after accept have no effect.
- in1 == in2 -> diff=0, zero=1, bout=0, ovf=0.
- Wrap-around: results are modulo 2^WIDTH. Borrow propagates across slice boundaries only via the carry reg.

Optional Feature:
SEQ_SUB_ADD_MODE_EN
- Defined: adds input port op (1 bit), sampled on accept. op=1 selects add: in2 is latched uninverted, carry reg <= 0, and bout reports the raw carry-out. op=0 behaves as subtract.
- Undefined: no op port; the block always subtracts.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE};
  - SLICE=8 constant;
  - counter width = clog2(NSLICE).
- Sub-module: instantiate existing team adder slice cla_8 once for the per-cycle slice add. Its ovf output feeds ovf on the final slice; pout/gout are unused.
- FSM, counter and operand shift registers stay in seq_sub_32.

Test Plan:
- in1=10, in2=3, start at t -> done pulse at t+5 only; diff=7, bout=0, ovf=0, zero=0; busy high t+1..t+4.
- in1=0x00000100, in2=1 -> diff=0x000000FF (borrow crosses slice 0->1), bout=0.
- in1=0, in2=1 -> diff=0xFFFFFFFF, bout=1, ovf=0. Then in1=0x80000000, in2=1 -> diff=0x7FFFFFFF, ovf=1, bout=0.
- in1=in2=0x5A5A5A5A -> diff=0, zero=1. A second start pulsed while busy, with different operands, is ignored: exactly one done, results unchanged.
- reset_n low at t+2 of an operation -> all outputs 0 immediately; no done. A fresh start after release completes normally.
- With SEQ_SUB_ADD_MODE_EN: op=1, in1=0xFFFFFFFF, in2=1 -> diff=0, bout=1 (carry), zero=1, ovf=0.
